// File: rtl/esfa_pkg.sv
// esfa_pkg: shared state encoding and default sizing for the ESFA trial scheduler
package esfa_pkg;
  localparam int          DEF_CNT_W   = 16;
  localparam int          DEF_TMO_W   = 24;
  localparam logic [23:0] DEF_TMO_CYC = 24'hFFFFFF;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_END   = 3'd3,
    RECORD     = 3'd4,
    TIMEOUT    = 3'd5,
    DONE       = 3'd6
  } state_e;
endpackage

// File: rtl/esfa_sat_counter.sv
// esfa_sat_counter: clearable up-counter that sticks at all-ones
module esfa_sat_counter
  import esfa_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/esfa_trial_scheduler.sv
// esfa_trial_scheduler: launches a batch of ESFA engine runs, times out stuck phases, keeps tallies
module esfa_trial_scheduler
  import esfa_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter int               TMO_W   = DEF_TMO_W,
  parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(DEF_TMO_CYC)
) (
  input  logic             masterClock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] trialCount,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             doRun,
  input  logic             isRunning,
  input  logic             wasSuccessful,
  output logic [CNT_W-1:0] trialsRun,
  output logic [CNT_W-1:0] successCount,
  output logic [CNT_W-1:0] timeoutCount
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             do_run_q, do_run_d;
  logic             abort_lat_q, abort_lat_d;
  logic             accept, finish, tmo_hit;
  logic             clr, run_inc, succ_inc, tmo_inc;

  always_comb begin
    accept      = start && state_q == IDLE && !busy_q;
    finish      = remaining_q == CNT_W'(1) || abort;
    tmo_hit     = timer_q == TMO_CYC;
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    abort_lat_d = abort_lat_q;
    clr         = 1'b0;
    run_inc     = 1'b0;
    succ_inc    = 1'b0;
    tmo_inc     = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        remaining_d = trialCount;
        abort_lat_d = 1'b0;
        clr         = 1'b1;
        state_d     = trialCount == '0 ? DONE : LAUNCH;
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        state_d = isRunning ? WAIT_END : tmo_hit ? TIMEOUT : WAIT_START;
        timer_d = isRunning ? '0 : tmo_hit ? timer_q : timer_q + 1'b1;
      end
      WAIT_END: begin
        state_d = !isRunning ? RECORD : tmo_hit ? TIMEOUT : WAIT_END;
        timer_d = (!isRunning || tmo_hit) ? timer_q : timer_q + 1'b1;
      end
      RECORD, TIMEOUT: begin
        run_inc     = 1'b1;
        succ_inc    = state_q == RECORD && wasSuccessful;
        tmo_inc     = state_q == TIMEOUT;
        remaining_d = remaining_q - 1'b1;
        abort_lat_d = abort_lat_q | abort;
        state_d     = finish ? DONE : LAUNCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    do_run_d  = state_q == LAUNCH;
    done_d    = state_q == DONE;
    aborted_d = state_q == DONE && abort_lat_q;
    // busy stays up through the done pulse and drops on the following cycle
    busy_d    = accept || (busy_q && !done_q);
  end

  always_ff @(posedge masterClock or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      do_run_q    <= 1'b0;
      abort_lat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      do_run_q    <= do_run_d;
      abort_lat_q <= abort_lat_d;
    end

  esfa_sat_counter #(.W(CNT_W)) u_runs (
    .clk(masterClock), .rst_n(reset), .clr(clr), .inc(run_inc), .cnt(trialsRun)
  );
  esfa_sat_counter #(.W(CNT_W)) u_succ (
    .clk(masterClock), .rst_n(reset), .clr(clr), .inc(succ_inc), .cnt(successCount)
  );
  esfa_sat_counter #(.W(CNT_W)) u_tmo (
    .clk(masterClock), .rst_n(reset), .clr(clr), .inc(tmo_inc), .cnt(timeoutCount)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign doRun   = do_run_q;
endmodule

// File: tb/tb_esfa_trial_scheduler.sv
// tb_esfa_trial_scheduler: directed scenarios against a small engine model, 4-bit tallies, 16-cycle timeout
module tb_esfa_trial_scheduler;
  localparam int CW = 4;
  logic          masterClock, reset, start, abort;
  logic [CW-1:0] trialCount;
  logic          busy, done, aborted, doRun, isRunning, wasSuccessful;
  logic [CW-1:0] trialsRun, successCount, timeoutCount;
  int            checks = 0, errors = 0;
  int            dorun_cnt, done_cnt;
  int            eng_mode = 2, eng_len = 0, eng_cnt;
  logic          eng_force = 1'b0, eng_force_succ = 1'b0;
  bit            succ_q[$];

  esfa_trial_scheduler #(.CNT_W(CW), .TMO_W(24), .TMO_CYC(24'd16)) dut (
    .masterClock(masterClock), .reset(reset), .start(start), .abort(abort),
    .trialCount(trialCount), .busy(busy), .done(done), .aborted(aborted),
    .doRun(doRun), .isRunning(isRunning), .wasSuccessful(wasSuccessful),
    .trialsRun(trialsRun), .successCount(successCount), .timeoutCount(timeoutCount)
  );

  initial begin
    masterClock = 1'b0;
    forever #5 masterClock = ~masterClock;
  end

  // engine model: mode 0 never responds, 1 runs eng_len cycles per doRun, 2 follows eng_force
  initial begin
    isRunning = 1'b0; wasSuccessful = 1'b0; eng_cnt = 0;
    forever begin
      @(negedge masterClock);
      if (eng_mode == 2) begin
        isRunning = eng_force; wasSuccessful = eng_force_succ; eng_cnt = 0;
      end else if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          isRunning = 1'b0;
          wasSuccessful = succ_q.size() != 0 ? succ_q.pop_front() : 1'b0;
        end
      end else if (eng_mode == 1 && doRun) begin
        isRunning = 1'b1; eng_cnt = eng_len;
      end
    end
  end

  initial begin
    dorun_cnt = 0; done_cnt = 0;
    forever begin
      @(negedge masterClock);
      if (doRun) dorun_cnt++;
      if (done) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required finish before 400000");
    $fatal(1, "watchdog expired");
  end

  task automatic set_engine(input int mode, input int len, input logic f, input logic fs);
    @(negedge masterClock);
    #1;
    eng_mode = mode; eng_len = len; eng_force = f; eng_force_succ = fs;
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    trialCount = n; start = 1'b1;
    @(negedge masterClock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge masterClock);
      seen = done;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; abort = 1'b0; trialCount = '0;
    repeat (3) @(negedge masterClock);
    checks++; if ({busy, done, aborted, doRun, trialsRun, successCount, timeoutCount} !== '0) begin errors++; $display("FAIL reset_held: got %h want 0", {busy, done, aborted, doRun, trialsRun, successCount, timeoutCount}); end
    reset = 1'b1;
    repeat (2) @(negedge masterClock);
    checks++; if ({busy, done, aborted, doRun, trialsRun, successCount, timeoutCount} !== '0) begin errors++; $display("FAIL reset_released: got %h want 0", {busy, done, aborted, doRun, trialsRun, successCount, timeoutCount}); end
  endtask

  task automatic test_latency;
    int b_run;
    set_engine(2, 0, 1'b1, 1'b1);
    @(negedge masterClock);
    b_run = dorun_cnt;
    pulse_start(4'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b want 1", busy); end
    checks++; if (doRun !== 1'b0) begin errors++; $display("FAIL lat_dorun_early: got %b want 0", doRun); end
    @(negedge masterClock);
    checks++; if (doRun !== 1'b1) begin errors++; $display("FAIL lat_dorun_prerunning: got %b want 1", doRun); end
    #1 eng_force = 1'b0;
    @(negedge masterClock);
    checks++; if (doRun !== 1'b0) begin errors++; $display("FAIL lat_dorun_width: got %b want 0", doRun); end
    @(negedge masterClock);
    @(negedge masterClock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lat_done_early: got %b want 0", done); end
    @(negedge masterClock);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL lat_done_3cyc: got %b want 1", done); end
    checks++; if (trialsRun !== 4'd1 || successCount !== 4'd1) begin errors++; $display("FAIL lat_tally: got %0d/%0d want 1/1", trialsRun, successCount); end
    @(negedge masterClock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL lat_busy_drop: got busy %b done %b want 0 0", busy, done); end
    checks++; if (dorun_cnt - b_run !== 1) begin errors++; $display("FAIL lat_dorun_count: got %0d want 1", dorun_cnt - b_run); end
  endtask

  task automatic test_basic;
    bit seen; int b_run, b_done;
    set_engine(2, 0, 1'b0, 1'b0);
    succ_q.delete(); succ_q.push_back(1'b1); succ_q.push_back(1'b0); succ_q.push_back(1'b1);
    set_engine(1, 10, 1'b0, 1'b0);
    b_run = dorun_cnt; b_done = done_cnt;
    pulse_start(4'd3);
    wait_done(300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL basic_done: no done within 300 cycles, want done"); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL basic_aborted: got %b want 0", aborted); end
    checks++; if (trialsRun !== 4'd3) begin errors++; $display("FAIL basic_trials: got %0d want 3", trialsRun); end
    checks++; if (successCount !== 4'd2) begin errors++; $display("FAIL basic_success: got %0d want 2", successCount); end
    checks++; if (timeoutCount !== 4'd0) begin errors++; $display("FAIL basic_timeouts: got %0d want 0", timeoutCount); end
    @(negedge masterClock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
    repeat (4) @(negedge masterClock);
    checks++; if (dorun_cnt - b_run !== 3 || done_cnt - b_done !== 1) begin errors++; $display("FAIL basic_pulses: got dorun %0d done %0d want 3 1", dorun_cnt - b_run, done_cnt - b_done); end
    checks++; if (trialsRun !== 4'd3 || successCount !== 4'd2) begin errors++; $display("FAIL basic_hold: got %0d/%0d want 3/2", trialsRun, successCount); end
  endtask

  task automatic test_zero;
    int b_run;
    b_run = dorun_cnt;
    pulse_start(4'd0);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_first: got done %b busy %b want 0 1", done, busy); end
    @(negedge masterClock);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if ({trialsRun, successCount, timeoutCount} !== '0) begin errors++; $display("FAIL zero_tally: got %0d/%0d/%0d want 0/0/0", trialsRun, successCount, timeoutCount); end
    @(negedge masterClock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_after: got busy %b done %b want 0 0", busy, done); end
    repeat (3) @(negedge masterClock);
    checks++; if (dorun_cnt - b_run !== 0) begin errors++; $display("FAIL zero_dorun: got %0d want 0", dorun_cnt - b_run); end
  endtask

  task automatic test_timeout;
    bit seen; int b_run;
    set_engine(0, 0, 1'b0, 1'b0);
    b_run = dorun_cnt;
    pulse_start(4'd2);
    wait_done(300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL tmo_done: no done within 300 cycles, want done"); end
    checks++; if (timeoutCount !== 4'd2 || trialsRun !== 4'd2) begin errors++; $display("FAIL tmo_tally: got tmo %0d runs %0d want 2 2", timeoutCount, trialsRun); end
    checks++; if (successCount !== 4'd0 || aborted !== 1'b0) begin errors++; $display("FAIL tmo_success: got %0d ab %b want 0 0", successCount, aborted); end
    repeat (4) @(negedge masterClock);
    checks++; if (dorun_cnt - b_run !== 2) begin errors++; $display("FAIL tmo_dorun: got %0d want 2", dorun_cnt - b_run); end
  endtask

  task automatic test_timeout_end;
    bit seen;
    succ_q.delete();
    set_engine(1, 1000, 1'b0, 1'b0);
    pulse_start(4'd1);
    wait_done(200, seen);
    checks++; if (!seen) begin errors++; $display("FAIL tmoend_done: no done within 200 cycles, want done"); end
    checks++; if (timeoutCount !== 4'd1 || trialsRun !== 4'd1 || successCount !== 4'd0) begin errors++; $display("FAIL tmoend_tally: got %0d/%0d/%0d want 1/1/0", timeoutCount, trialsRun, successCount); end
    set_engine(2, 0, 1'b0, 1'b0);
    repeat (3) @(negedge masterClock);
  endtask

  task automatic test_abort;
    bit seen; int b_run, b_done, n;
    succ_q.delete(); repeat (5) succ_q.push_back(1'b1);
    set_engine(1, 10, 1'b0, 1'b0);
    b_run = dorun_cnt; b_done = done_cnt;
    pulse_start(4'd5);
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge masterClock);
      if (doRun) n++;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL abort_second_run: got %0d doRun want 2", n); end
    abort = 1'b1;
    wait_done(200, seen);
    checks++; if (!seen || aborted !== 1'b1) begin errors++; $display("FAIL abort_flag: got done %b aborted %b want 1 1", seen, aborted); end
    checks++; if (trialsRun !== 4'd2 || successCount !== 4'd2) begin errors++; $display("FAIL abort_tally: got %0d/%0d want 2/2", trialsRun, successCount); end
    abort = 1'b0;
    repeat (5) @(negedge masterClock);
    checks++; if (dorun_cnt - b_run !== 2 || done_cnt - b_done !== 1) begin errors++; $display("FAIL abort_pulses: got dorun %0d done %0d want 2 1", dorun_cnt - b_run, done_cnt - b_done); end
    succ_q.delete(); succ_q.push_back(1'b1);
    abort = 1'b1;
    pulse_start(4'd3);
    wait_done(200, seen);
    checks++; if (!seen || aborted !== 1'b1 || trialsRun !== 4'd1) begin errors++; $display("FAIL abort_with_start: got done %b ab %b runs %0d want 1 1 1", seen, aborted, trialsRun); end
    abort = 1'b0;
    repeat (3) @(negedge masterClock);
    abort = 1'b1;
    repeat (3) @(negedge masterClock);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy: got %b want 0", busy); end
    succ_q.delete(); succ_q.push_back(1'b0);
    pulse_start(4'd1);
    wait_done(200, seen);
    checks++; if (!seen || aborted !== 1'b0 || trialsRun !== 4'd1) begin errors++; $display("FAIL abort_idle_ignored: got done %b ab %b runs %0d want 1 0 1", seen, aborted, trialsRun); end
    repeat (3) @(negedge masterClock);
  endtask

  task automatic test_reset_mid;
    bit seen; int n;
    succ_q.delete(); repeat (3) succ_q.push_back(1'b1);
    set_engine(1, 20, 1'b0, 1'b0);
    pulse_start(4'd3);
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge masterClock);
      if (doRun) n++;
    end
    repeat (5) @(negedge masterClock);
    checks++; if (busy !== 1'b1 || trialsRun !== 4'd1) begin errors++; $display("FAIL rst_pre: got busy %b runs %0d want 1 1", busy, trialsRun); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({busy, done, aborted, doRun, trialsRun, successCount, timeoutCount} !== '0) begin errors++; $display("FAIL rst_async: got %h want 0", {busy, done, aborted, doRun, trialsRun, successCount, timeoutCount}); end
    set_engine(2, 0, 1'b0, 1'b0);
    @(negedge masterClock);
    reset = 1'b1;
    succ_q.delete(); succ_q.push_back(1'b1);
    set_engine(1, 4, 1'b0, 1'b0);
    @(negedge masterClock);
    pulse_start(4'd1);
    wait_done(200, seen);
    checks++; if (!seen || trialsRun !== 4'd1 || successCount !== 4'd1 || timeoutCount !== 4'd0) begin errors++; $display("FAIL rst_recover: got done %b %0d/%0d/%0d want 1 1/1/0", seen, trialsRun, successCount, timeoutCount); end
    repeat (3) @(negedge masterClock);
  endtask

  task automatic test_back_to_back;
    bit seen; int b_run, b_done;
    succ_q.delete();
    for (int i = 0; i < 15; i++) succ_q.push_back(i % 3 == 0);
    set_engine(1, 2, 1'b0, 1'b0);
    b_run = dorun_cnt; b_done = done_cnt;
    pulse_start(4'd15);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge masterClock);
      seen = done;
      if (!seen) begin
        start = (i % 7 == 3);
        trialCount = 4'd3;
      end
    end
    start = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL b2b_done: no done within 400 cycles, want done"); end
    checks++; if (trialsRun !== 4'd15) begin errors++; $display("FAIL b2b_trials: got %0d want 15", trialsRun); end
    checks++; if (successCount !== 4'd5 || timeoutCount !== 4'd0) begin errors++; $display("FAIL b2b_tally: got %0d/%0d want 5/0", successCount, timeoutCount); end
    repeat (5) @(negedge masterClock);
    checks++; if (busy !== 1'b0 || trialsRun !== 4'd15) begin errors++; $display("FAIL b2b_idle: got busy %b runs %0d want 0 15", busy, trialsRun); end
    checks++; if (dorun_cnt - b_run !== 15 || done_cnt - b_done !== 1) begin errors++; $display("FAIL b2b_pulses: got dorun %0d done %0d want 15 1", dorun_cnt - b_run, done_cnt - b_done); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_basic;
    test_zero;
    test_timeout;
    test_timeout_end;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
